// File: rtl/spi_pkg.sv
// Shared types and mode encodings for the parametrised SPI master.
`default_nettype none

package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  localparam logic [1:0] MODE_0 = 2'd0;
  localparam logic [1:0] MODE_1 = 2'd1;
  localparam logic [1:0] MODE_2 = 2'd2;
  localparam logic [1:0] MODE_3 = 2'd3;

  function automatic logic [1:0] mode_num(input spi_mode_t m);
    return {m.cpol, m.cpha};
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: one-cycle tick every CLK_DIV enabled cycles.
`default_nettype none

module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == TERMINAL);

  // Counter is held at zero while disabled so each transfer starts phase-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable width, divider, mode, bit order and chip selects.
`default_nettype none

module spi_master_param
  import spi_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int CLK_DIV = 4,
  parameter  int NUM_CS  = 2,
  localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] LAST_CNT = BC_W'(DATA_W);

  spi_state_t        state, next_state;
  spi_mode_t         mode_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [BC_W-1:0]   bit_cnt;
  logic [BC_W-1:0]   bit_cnt_inc;
  logic              lead_next;
  logic              tick;
  logic              accept;
  logic              edge_ev;
  logic              sample_ev;
  logic              drive_ev;
  logic              last_edge;
  logic              sample_on_lead;
  logic [NUM_CS-1:0] cs_dec_n;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state != IDLE),
    .tick (tick)
  );

  // Out-of-range cs_sel decodes to no active select.
  for (genvar i = 0; i < NUM_CS; i++) begin : g_cs_dec
    assign cs_dec_n[i] = (cs_sel != CS_W'(i));
  end

  always_comb begin
    sample_on_lead = 1'b1;
    case (mode_num(mode_q))
      MODE_0, MODE_2: sample_on_lead = 1'b1;
      MODE_1, MODE_3: sample_on_lead = 1'b0;
      default:        sample_on_lead = 1'b1;
    endcase
  end

  assign accept      = (state == IDLE) && start && !busy;
  assign edge_ev     = tick && ((state == LEAD) || (state == SHIFT));
  assign sample_ev   = edge_ev && (lead_next == sample_on_lead);
  assign bit_cnt_inc = sample_ev ? (bit_cnt + BC_W'(1)) : bit_cnt;
  // The final edge is always trailing and follows (or carries) the last sample.
  assign last_edge   = edge_ev && !lead_next && (bit_cnt_inc == LAST_CNT);
  assign drive_ev    = edge_ev && !sample_ev && !last_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)    next_state = LEAD;
      LEAD:    if (edge_ev)   next_state = SHIFT;
      SHIFT:   if (last_edge) next_state = TRAIL;
      TRAIL:   if (tick)      next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= '1;
      mode_q    <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      lead_next <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          busy <= accept;
          if (accept) begin
            mode_q    <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
            rx_sr     <= '0;
            bit_cnt   <= '0;
            lead_next <= 1'b1;
            cs_n      <= cs_dec_n;
            // With CPHA=0 the first bit must be on the wire before the first edge.
            if (!cpha) begin
              mosi  <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
              tx_sr <= lsb_first ? (tx_data >> 1) : (tx_data << 1);
            end else begin
              tx_sr <= tx_data;
            end
          end
        end
        LEAD, SHIFT: begin
          if (edge_ev) begin
            sclk      <= ~sclk;
            lead_next <= ~lead_next;
            bit_cnt   <= bit_cnt_inc;
          end
          if (sample_ev) begin
            rx_sr <= mode_q.lsb_first ? {miso, rx_sr[DATA_W-1:1]}
                                      : {rx_sr[DATA_W-2:0], miso};
          end
          if (drive_ev) begin
            mosi  <= mode_q.lsb_first ? tx_sr[0] : tx_sr[DATA_W-1];
            tx_sr <= mode_q.lsb_first ? (tx_sr >> 1) : (tx_sr << 1);
          end
        end
        TRAIL: begin
          if (tick) begin
            cs_n    <= '1;
            mosi    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
